// File: rtl/cam_frame_writer.sv
// rtl/cam_frame_writer.sv - OV7670-style camera capture into a linear RGB565 frame buffer
// Camera signals are oversampled on clk; all pixel events key off a detected pclk rising edge.
module cam_frame_writer #(
  parameter int H_ACTIVE = 320,
  parameter int V_ACTIVE = 240,
  parameter int ADDR_W   = 17
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              capture_en,
  input  logic              cam_pclk,
  input  logic              cam_vsync,
  input  logic              cam_href,
  input  logic [7:0]        cam_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data,
  output logic              capturing,
  output logic              frame_done,
  output logic              frame_err,
  output logic [7:0]        frame_count
);

  localparam int COL_W = $clog2(H_ACTIVE + 1);
  localparam int ROW_W = $clog2(V_ACTIVE + 1);

  typedef enum logic [1:0] {IDLE, SYNC, ACTIVE} state_t;

  state_t r_state, w_next;

  logic r_pclk_s1, r_pclk_s2, r_pclk_d;
  logic r_vs_s1, r_vs_s2, r_vs_d;
  logic r_href_s1, r_href_s2, r_href_d;
  logic [7:0] r_data_s1, r_data_s2;

  logic [7:0]        r_hi;
  logic              r_phase;
  logic [COL_W-1:0]  r_col;
  logic [ROW_W-1:0]  r_row;
  logic [ADDR_W-1:0] r_base;

  logic w_pclk_rise, w_vs_rise, w_vs_fall, w_href_fall;
  logic w_start, w_end;

  assign w_pclk_rise = r_pclk_s2 & ~r_pclk_d;
  assign w_vs_rise   = r_vs_s2 & ~r_vs_d;
  assign w_vs_fall   = ~r_vs_s2 & r_vs_d;
  assign w_href_fall = ~r_href_s2 & r_href_d;
  assign w_start     = (r_state == SYNC) && w_vs_fall && capture_en;
  assign w_end       = (r_state == ACTIVE) && w_vs_rise;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pclk_s1 <= 1'b0; r_pclk_s2 <= 1'b0; r_pclk_d <= 1'b0;
      r_vs_s1   <= 1'b0; r_vs_s2   <= 1'b0; r_vs_d   <= 1'b0;
      r_href_s1 <= 1'b0; r_href_s2 <= 1'b0; r_href_d <= 1'b0;
      r_data_s1 <= 8'd0; r_data_s2 <= 8'd0;
    end else begin
      r_pclk_s1 <= cam_pclk;  r_pclk_s2 <= r_pclk_s1; r_pclk_d <= r_pclk_s2;
      r_vs_s1   <= cam_vsync; r_vs_s2   <= r_vs_s1;   r_vs_d   <= r_vs_s2;
      r_href_s1 <= cam_href;  r_href_s2 <= r_href_s1; r_href_d <= r_href_s2;
      r_data_s1 <= cam_data;  r_data_s2 <= r_data_s1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // IDLE only leaves on a vsync rise, so capture never begins part-way through a frame.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_vs_rise) w_next = SYNC;
      SYNC:    if (w_vs_fall && capture_en) w_next = ACTIVE;
      ACTIVE:  if (w_vs_rise) w_next = SYNC;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= 16'd0;
      capturing   <= 1'b0;
      frame_done  <= 1'b0;
      frame_err   <= 1'b0;
      frame_count <= 8'd0;
      r_hi        <= 8'd0;
      r_phase     <= 1'b0;
      r_col       <= '0;
      r_row       <= '0;
      r_base      <= '0;
    end else begin
      wr_en      <= 1'b0;
      frame_done <= 1'b0;
      if (w_start) begin
        capturing <= 1'b1;
        r_row     <= '0;
        r_col     <= '0;
        r_base    <= '0;
        r_phase   <= 1'b0;
      end else if (w_end) begin
        capturing   <= 1'b0;
        frame_done  <= 1'b1;
        frame_count <= frame_count + 8'd1;
        if (r_row != ROW_W'(V_ACTIVE)) frame_err <= 1'b1;
      end else if (r_state == ACTIVE) begin
        if (w_href_fall) begin
          // Row and base saturate at V_ACTIVE so surplus lines are silently dropped.
          if (r_col != '0) begin
            r_col <= '0;
            if (r_row != ROW_W'(V_ACTIVE)) begin
              r_row  <= r_row + 1'b1;
              r_base <= r_base + ADDR_W'(H_ACTIVE);
            end
          end
          if (r_phase) begin
            r_phase   <= 1'b0;
            frame_err <= 1'b1;
          end
        end else if (w_pclk_rise && r_href_s2) begin
          if (!r_phase) begin
            r_hi    <= r_data_s2;
            r_phase <= 1'b1;
          end else begin
            r_phase <= 1'b0;
            if (r_col < COL_W'(H_ACTIVE) && r_row < ROW_W'(V_ACTIVE)) begin
              wr_en   <= 1'b1;
              wr_addr <= r_base + ADDR_W'(r_col);
              wr_data <= {r_hi, r_data_s2};
              r_col   <= r_col + 1'b1;
            end else if (r_col >= COL_W'(H_ACTIVE)) begin
              frame_err <= 1'b1;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_cam_frame_writer.sv
// tb/tb_cam_frame_writer.sv - scoreboard bench for cam_frame_writer on a reduced 16x8 frame
module tb_cam_frame_writer;

  localparam int H = 16;
  localparam int V = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        capture_en = 1'b1;
  logic        cam_pclk = 1'b0;
  logic        cam_vsync = 1'b0;
  logic        cam_href = 1'b0;
  logic [7:0]  cam_data = 8'd0;
  logic        wr_en;
  logic [16:0] wr_addr;
  logic [15:0] wr_data;
  logic        capturing;
  logic        frame_done;
  logic        frame_err;
  logic [7:0]  frame_count;

  cam_frame_writer #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(17)) dut (
    .clk(clk), .reset(reset), .capture_en(capture_en),
    .cam_pclk(cam_pclk), .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_data(cam_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .capturing(capturing), .frame_done(frame_done), .frame_err(frame_err),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [16:0] addr;
    logic [15:0] data;
    logic [31:0] cyc;
  } exp_t;

  exp_t expq[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   n_writes = 0;
  int   n_done = 0;
  int   m_row = 0;
  bit   m_cap = 1'b0;
  bit   use_special = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (frame_done) n_done++;
    if (wr_en) begin
      n_writes++;
      if (expq.size() == 0) begin
        check("unexpected_write_addr", {15'd0, wr_addr}, 32'hFFFF_FFFF);
      end else begin
        e = expq.pop_front();
        check("wr_addr", {15'd0, wr_addr}, {15'd0, e.addr});
        check("wr_data", {16'd0, wr_data}, {16'd0, e.data});
        check("wr_latency_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog: cycle budget exhausted at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit push, input logic [16:0] a,
                           input logic [15:0] d);
    cam_data = b;
    cam_href = 1'b1;
    tick(2);
    cam_pclk = 1'b1;
    if (push) expq.push_back({a, d, 32'(cyc + 3)});
    tick(2);
    cam_pclk = 1'b0;
  endtask

  task automatic send_line(input int nbytes);
    logic [7:0] hi, lo;
    for (int k = 0; k < nbytes; k++) begin
      int pix;
      pix = k / 2;
      hi = (use_special && m_row == 2 && pix == 5) ? 8'h12 : 8'hAB;
      lo = (use_special && m_row == 2 && pix == 5) ? 8'h34 : 8'hCD;
      if (k % 2 == 0) send_byte(hi, 1'b0, 17'd0, 16'd0);
      else send_byte(lo, m_cap && pix < H && m_row < V, 17'(m_row * H + pix), {hi, lo});
    end
    cam_href = 1'b0;
    tick(12);
    if (m_cap && nbytes >= 2 && m_row < V) m_row++;
  endtask

  task automatic vs_high();
    cam_vsync = 1'b1;
    tick(16);
  endtask

  task automatic vs_low(input bit cap);
    capture_en = cap;
    cam_vsync = 1'b0;
    tick(16);
    m_row = 0;
    m_cap = cap;
  endtask

  task automatic pulse_reset();
    cam_vsync = 1'b0;
    reset = 1'b0;
    tick(6);
    reset = 1'b1;
    tick(4);
    m_cap = 1'b0;
  endtask

  task automatic end_check(input string tag, input int cnt, input bit err, input int done0,
                           input int done_delta, input int wr0, input int wr_delta);
    check({tag, "_frame_count"}, {24'd0, frame_count}, cnt);
    check({tag, "_frame_err"}, {31'd0, frame_err}, {31'd0, err});
    check({tag, "_done_pulses"}, n_done - done0, done_delta);
    check({tag, "_writes"}, n_writes - wr0, wr_delta);
    check({tag, "_capturing"}, {31'd0, capturing}, 32'd0);
    check({tag, "_queue_empty"}, expq.size(), 32'd0);
  endtask

  initial begin
    int d0, w0;
    tick(5);
    check("rst_wr_en", {31'd0, wr_en}, 32'd0);
    check("rst_wr_addr", {15'd0, wr_addr}, 32'd0);
    check("rst_wr_data", {16'd0, wr_data}, 32'd0);
    check("rst_capturing", {31'd0, capturing}, 32'd0);
    check("rst_frame_done", {31'd0, frame_done}, 32'd0);
    check("rst_frame_err", {31'd0, frame_err}, 32'd0);
    check("rst_frame_count", {24'd0, frame_count}, 32'd0);
    reset = 1'b1;
    tick(4);

    // Full frame; pixel (5,2) carries 0x1234 at address 2*16+5.
    use_special = 1'b1;
    d0 = n_done; w0 = n_writes;
    vs_high(); vs_low(1'b1);
    check("f1_capturing", {31'd0, capturing}, 32'd1);
    for (int r = 0; r < V; r++) send_line(2 * H);
    use_special = 1'b0;
    vs_high();
    end_check("f1", 1, 1'b0, d0, 1, w0, H * V);

    // Frozen frame.
    d0 = n_done; w0 = n_writes;
    vs_low(1'b0);
    check("f2_capturing", {31'd0, capturing}, 32'd0);
    for (int r = 0; r < V; r++) send_line(2 * H);
    vs_high();
    end_check("f2", 1, 1'b0, d0, 0, w0, 0);

    // Capture re-enabled; dropping capture_en mid-frame must not stop it.
    d0 = n_done; w0 = n_writes;
    vs_low(1'b1);
    capture_en = 1'b0;
    for (int r = 0; r < V; r++) send_line(2 * H);
    vs_high();
    end_check("f3", 2, 1'b0, d0, 1, w0, H * V);
    capture_en = 1'b1;

    // Long line on row 1: 18 pixels, only 16 written, next row at base+16.
    d0 = n_done; w0 = n_writes;
    vs_low(1'b1);
    send_line(2 * H);
    send_line(2 * H + 4);
    check("f4_err_after_long", {31'd0, frame_err}, 32'd1);
    for (int r = 2; r < V; r++) send_line(2 * H);
    vs_high();
    end_check("f4", 3, 1'b1, d0, 1, w0, H * V);

    // Odd byte count on line 0.
    pulse_reset();
    check("rst2_frame_err", {31'd0, frame_err}, 32'd0);
    check("rst2_frame_count", {24'd0, frame_count}, 32'd0);
    d0 = n_done; w0 = n_writes;
    vs_high(); vs_low(1'b1);
    send_line(3);
    check("f5_err_after_odd", {31'd0, frame_err}, 32'd1);
    check("f5_odd_line_writes", n_writes - w0, 32'd1);
    for (int r = 1; r < V; r++) send_line(2 * H);
    vs_high();
    end_check("f5", 1, 1'b1, d0, 1, w0, 1 + H * (V - 1));

    // Short frame of 5 lines.
    pulse_reset();
    d0 = n_done; w0 = n_writes;
    vs_high(); vs_low(1'b1);
    for (int r = 0; r < 5; r++) send_line(2 * H);
    vs_high();
    end_check("f6", 1, 1'b1, d0, 1, w0, H * 5);

    // Extra lines beyond V are dropped without error.
    pulse_reset();
    d0 = n_done; w0 = n_writes;
    vs_high(); vs_low(1'b1);
    for (int r = 0; r < V + 2; r++) send_line(2 * H);
    vs_high();
    end_check("f7", 1, 1'b0, d0, 1, w0, H * V);

    // Reset lands on the cycle the pending write would be issued.
    vs_low(1'b1);
    for (int r = 0; r < 4; r++) send_line(2 * H);
    send_line(0);
    send_byte(8'hAB, 1'b0, 17'd0, 16'd0);
    send_byte(8'hCD, 1'b1, 17'(m_row * H), 16'hABCD);
    send_byte(8'h55, 1'b0, 17'd0, 16'd0);
    cam_data = 8'h66;
    tick(2);
    cam_pclk = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(1);
    check("mid_rst_wr_en", {31'd0, wr_en}, 32'd0);
    check("mid_rst_capturing", {31'd0, capturing}, 32'd0);
    cam_pclk = 1'b0;
    cam_href = 1'b0;
    tick(2);
    reset = 1'b1;
    tick(4);
    m_cap = 1'b0;
    w0 = n_writes;
    send_line(2 * H);
    send_line(2 * H);
    check("post_rst_idle_writes", n_writes - w0, 32'd0);
    d0 = n_done; w0 = n_writes;
    vs_high(); vs_low(1'b1);
    for (int r = 0; r < V; r++) send_line(2 * H);
    vs_high();
    end_check("f8", 1, 1'b0, d0, 1, w0, H * V);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cam_frame_writer.md
Name: cam_frame_writer

Overview:
- Captures RGB565 pixels from the OV7670-style 8-bit camera bus and writes them into the 320x240 QVGA frame buffer.
- Drives the buffer's write port. The colour-detection and VGA logic read the same buffer during blanking.
- Converts camera pclk/href/vsync timing into linear addresses 0..76799, one 16-bit word per pixel.
- Frames can be frozen via capture_en, so readers see a stable image.

Parameters:
- H_ACTIVE, 320, pixels per line written.
- V_ACTIVE, 240, lines per frame written.
- ADDR_W, 17, frame buffer address width.

Ports:
- clk  in  1  system clock; cam_pclk is at most clk/4.
- reset  in  1  synchronous, active-low reset.
- capture_en  in  1  capture allowed; sampled only at frame start.
- cam_pclk  in  1  camera pixel clock, asynchronous, sampled.
- cam_vsync  in  1  camera vsync; high = vertical blanking.
- cam_href  in  1  camera line valid.
- cam_data  in  8  camera byte bus.
- wr_en  out  1  frame buffer write strobe, one clk wide.
- wr_addr  out  ADDR_W  write address = row*H_ACTIVE + col.
- wr_data  out  16  RGB565 pixel; first byte is [15:8], second byte is [7:0].
- capturing  out  1  high while a frame is being written.
- frame_done  out  1  one-clk pulse at end of a captured frame.
- frame_err  out  1  sticky; cleared by reset only.
- frame_count  out  8  captured-frame counter; wraps 255->0.

Behaviour:
- Input synchronisation:
  - cam_pclk, cam_vsync, cam_href and cam_data each pass through 2 flops.
  - A pclk rising edge is detected when sync2=1 and the previous value was 0.
  - All camera events are evaluated only on a detected pclk edge, using synced href/data.
- Reset values: all outputs 0, state = IDLE, byte_phase = 0, col = 0, row = 0.
- State IDLE:
  - Waits for the synced cam_vsync to rise, then goes to SYNC. No writes occur.
  - Guarantees capture never starts mid-frame.
- State SYNC (vsync high):
  - On vsync falling edge with capture_en=1: go to ACTIVE, set capturing=1, clear row, col and byte_phase.
  - On vsync falling edge with capture_en=0: stay in SYNC and skip this frame.
- State ACTIVE, on each pclk edge with href=1:
  - byte_phase=0: latch the byte as the high byte, then set byte_phase=1.
  - byte_phase=1: form the word and set byte_phase=0.
  - If col<H_ACTIVE and row<V_ACTIVE: issue a write and increment col.
  - Otherwise drop the word; if col>=H_ACTIVE, set frame_err.
- Write latency: wr_en, wr_addr and wr_data are registered. wr_en goes high exactly 3 clk after the low byte's cam_pclk rising edge at the port, with data held stable on the ports.
- href falling edge (synced, evaluated on clk) inside ACTIVE:
  - If col>0: row++, col=0.
  - If byte_phase=1: discard the dangling high byte, set byte_phase=0, set frame_err.
  - A line shorter than H_ACTIVE advances the row; missing pixels are not written and no error is raised.
- Lines beyond V_ACTIVE are dropped without error.
- Address generation is incremental (no multiplier): a base register adds H_ACTIVE per line, and wr_addr = base + col. Maximum address is 76799.
- vsync rising edge in ACTIVE (end of frame):
  - Set capturing=0 and pulse frame_done for 1 clk.
  - Increment frame_count.
  - If row != V_ACTIVE, set frame_err.
  - Go to SYNC; the next frame obeys capture_en again.
- Deasserting capture_en mid-frame has no effect until the next frame start.
- Reset low mid-frame: all outputs are cleared on the next clk edge and the FSM returns to IDLE. The partial frame is abandoned.

Test Plan:
1. Full frame: reset, vsync pulse, then 240 lines of 320 pixels with bytes 0xAB,0xCD, capture_en=1 -> 76800 writes, wr_data=0xABCD, addresses 0..76799 in order, one frame_done, frame_count=1, frame_err=0.
2. Latency/mapping: pixel (col 5, row 2) with bytes 0x12,0x34 -> wr_addr=645, wr_data=0x1234, wr_en exactly 3 clk after its second pclk rise.
3. Freeze: capture_en=0 at vsync fall of frame 2 -> zero writes during frame 2, frame_count stays 1; re-enable before frame 3 -> frame 3 fully written.
4. Long line: a line with 322 pixels -> only 320 writes for that row, frame_err=1, next row starts at base+320.
5. Odd bytes/short frame: href drops after 3 bytes on line 0 -> 1 write, frame_err=1. A frame of 200 lines -> frame_done pulses, frame_err=1.
6. Reset mid-frame at row 100 -> wr_en=0 and capturing=0 next clk. No writes until a full vsync high→low cycle occurs; the restarted frame begins at wr_addr=0.
